// File: rtl/video_palout.sv
// Palette lookup and DAC output stage: a two-stage pipeline from colour index and
// video timing flags to registered RGB and sync outputs, with banked palette RAM and readback.
module video_palout #(
    parameter int IDX_W = 4,
    parameter int CW    = 2,
    parameter int NBANK = 2,
    localparam int BW   = $clog2(NBANK),
    localparam int PW   = 3*CW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] pixel,
    input  logic [IDX_W-1:0] border,
    input  logic             hpix,
    input  logic             vpix,
    input  logic             hblank,
    input  logic             vblank,
    input  logic             hsync,
    input  logic             vsync,
    input  logic [BW-1:0]    bank_sel,
    input  logic             wr_stb,
    input  logic [BW-1:0]    wr_bank,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [PW-1:0]    wr_data,
    input  logic [BW-1:0]    rd_bank,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [PW-1:0]    rd_data,
    output logic [CW-1:0]    vgrn,
    output logic [CW-1:0]    vred,
    output logic [CW-1:0]    vblu,
    output logic             vhsync,
    output logic             vvsync,
    output logic             vcsync,
    output logic [BW-1:0]    act_bank
);

    localparam int NENT = 2**IDX_W;

    logic [PW-1:0]    r_pal [NBANK][NENT];
    logic [IDX_W-1:0] r_idx1;
    logic             r_blk1;
    logic             r_hs1;
    logic             r_vs1;
    logic             r_vs1_d;
    logic [BW-1:0]    r_act_bank;
    logic [PW-1:0]    r_colour;
    logic             r_vhsync;
    logic             r_vvsync;
    logic             r_vcsync;
    logic [PW-1:0]    r_rd_data;

    logic [IDX_W-1:0] w_idx0;
    logic             w_vid_fwd;
    logic             w_rd_fwd;
    logic             w_vs_rise;
    logic [PW-1:0]    w_lut;
    logic [PW-1:0]    w_rd_val;

    // Default entry: blu/red/grn from index bits 0..2, bit 3 selects full vs half level.
    function automatic logic [PW-1:0] f_default(input int unsigned i);
        logic [CW-1:0] lvl;
        lvl = i[3] ? {CW{1'b1}} : {1'b1, {(CW-1){1'b0}}};
        return {i[2] ? lvl : {CW{1'b0}},
                i[1] ? lvl : {CW{1'b0}},
                i[0] ? lvl : {CW{1'b0}}};
    endfunction

    assign w_idx0    = (hpix & vpix) ? pixel : border;
    assign w_vs_rise = r_vs1 & ~r_vs1_d;
    assign w_vid_fwd = wr_stb && (wr_bank == r_act_bank) && (wr_idx == r_idx1);
    assign w_lut     = w_vid_fwd ? wr_data : r_pal[r_act_bank][r_idx1];
    assign w_rd_fwd  = wr_stb && (wr_bank == rd_bank) && (wr_idx == rd_idx);
    assign w_rd_val  = w_rd_fwd ? wr_data : r_pal[rd_bank][rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NBANK; b++) begin
                for (int e = 0; e < NENT; e++) begin
                    r_pal[b][e] <= f_default(e);
                end
            end
        end else if (wr_stb) begin
            r_pal[wr_bank][wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx1     <= '0;
            r_blk1     <= 1'b0;
            r_hs1      <= 1'b0;
            r_vs1      <= 1'b0;
            r_vs1_d    <= 1'b0;
            r_act_bank <= '0;
            r_colour   <= '0;
            r_vhsync   <= 1'b0;
            r_vvsync   <= 1'b0;
            r_vcsync   <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_idx1   <= w_idx0;
            r_blk1   <= hblank | vblank;
            r_hs1    <= hsync;
            r_vs1    <= vsync;
            r_vs1_d  <= r_vs1;
            // Bank swap lands on the same edge that loads the next index.
            if (w_vs_rise) begin
                r_act_bank <= bank_sel;
            end
            r_colour  <= r_blk1 ? '0 : w_lut;
            r_vhsync  <= r_hs1;
            r_vvsync  <= r_vs1;
            r_vcsync  <= ~(r_hs1 ^ r_vs1);
            r_rd_data <= w_rd_val;
        end
    end

    assign vgrn     = r_colour[3*CW-1:2*CW];
    assign vred     = r_colour[2*CW-1:CW];
    assign vblu     = r_colour[CW-1:0];
    assign vhsync   = r_vhsync;
    assign vvsync   = r_vvsync;
    assign vcsync   = r_vcsync;
    assign act_bank = r_act_bank;
    assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_video_palout.sv
// Scoreboard bench for video_palout: drivers queue expected outputs, a monitor pops them
// when the delayed check flags say the DUT output belongs to a queued vector.
module tb_video_palout;

    logic       clk;
    logic       rst_n;
    logic [3:0] pixel, border;
    logic       hpix, vpix, hblank, vblank, hsync, vsync;
    logic [0:0] bank_sel;
    logic       wr_stb;
    logic [0:0] wr_bank;
    logic [3:0] wr_idx;
    logic [5:0] wr_data;
    logic [0:0] rd_bank;
    logic [3:0] rd_idx;
    logic [5:0] rd_data;
    logic [1:0] vgrn, vred, vblu;
    logic       vhsync, vvsync, vcsync;
    logic [0:0] act_bank;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] vq [$];
    logic [5:0] rq [$];
    int         vid_id = 0;
    int         rd_id  = 0;
    logic       chk_vid, chk_rd;
    logic [1:0] vpipe;
    logic       rpipe;

    video_palout dut (
        .clk(clk), .rst_n(rst_n),
        .pixel(pixel), .border(border),
        .hpix(hpix), .vpix(vpix), .hblank(hblank), .vblank(vblank),
        .hsync(hsync), .vsync(vsync),
        .bank_sel(bank_sel),
        .wr_stb(wr_stb), .wr_bank(wr_bank), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_bank(rd_bank), .rd_idx(rd_idx), .rd_data(rd_data),
        .vgrn(vgrn), .vred(vred), .vblu(vblu),
        .vhsync(vhsync), .vvsync(vvsync), .vcsync(vcsync),
        .act_bank(act_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Check flags travel alongside the data: 2 cycles for video, 1 for readback.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= 2'b00;
            rpipe <= 1'b0;
        end else begin
            vpipe <= {vpipe[0], chk_vid};
            rpipe <= chk_rd;
        end
    end

    always @(negedge clk) begin
        logic [8:0] ev, av;
        logic [5:0] er;
        if (rst_n && vpipe[1]) begin
            n_vec++;
            if (vq.size() == 0) begin
                n_err++;
                $display("FAIL vid_underflow: output due but no expectation queued");
            end else begin
                ev = vq.pop_front();
                av = {vgrn, vred, vblu, vhsync, vvsync, vcsync};
                if (av !== ev) begin
                    n_err++;
                    $display("FAIL vid#%0d: got col=%h hs=%b vs=%b cs=%b, want col=%h hs=%b vs=%b cs=%b",
                             vid_id, av[8:3], av[2], av[1], av[0], ev[8:3], ev[2], ev[1], ev[0]);
                end
                vid_id++;
            end
        end
        if (rst_n && rpipe) begin
            n_vec++;
            if (rq.size() == 0) begin
                n_err++;
                $display("FAIL rd_underflow: readback due but no expectation queued");
            end else begin
                er = rq.pop_front();
                if (rd_data !== er) begin
                    n_err++;
                    $display("FAIL rd#%0d: got rd_data=%h, want %h", rd_id, rd_data, er);
                end
                rd_id++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        chk_vid = 1'b0;
        chk_rd  = 1'b0;
        wr_stb  = 1'b0;
    endtask

    task automatic vid(input logic [3:0] pix, input logic [3:0] brd,
                       input logic hp, input logic vp, input logic hb, input logic vb,
                       input logic hs, input logic vs, input logic [5:0] col);
        pixel = pix; border = brd; hpix = hp; vpix = vp;
        hblank = hb; vblank = vb; hsync = hs; vsync = vs;
        vq.push_back({col, hs, vs, ~(hs ^ vs)});
        chk_vid = 1'b1;
        cyc();
    endtask

    task automatic act(input logic [3:0] pix, input logic [5:0] col);
        vid(pix, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, col);
    endtask

    task automatic wr(input logic b, input logic [3:0] idx, input logic [5:0] d);
        wr_stb = 1'b1; wr_bank = b; wr_idx = idx; wr_data = d;
    endtask

    task automatic rd(input logic b, input logic [3:0] idx, input logic [5:0] exp);
        rd_bank = b; rd_idx = idx; chk_rd = 1'b1;
        rq.push_back(exp);
    endtask

    initial begin
        rst_n = 1'b1;
        pixel = '0; border = '0; hpix = 0; vpix = 0; hblank = 0; vblank = 0;
        hsync = 0; vsync = 0; bank_sel = '0;
        wr_stb = 0; wr_bank = '0; wr_idx = '0; wr_data = '0;
        rd_bank = '0; rd_idx = '0; chk_vid = 0; chk_rd = 0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {20'h0, vgrn, vred, vblu, vhsync, vvsync, vcsync}, 32'h0);
        check("reset_act_bank", {31'h0, act_bank}, 32'h0);
        check("reset_rd_data", {26'h0, rd_data}, 32'h0);
        rst_n = 1'b1;

        act(4'hE, 6'h3C);
        act(4'h5, 6'h22);
        vid(4'h0, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h08);
        vid(4'hE, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00);
        vid(4'hE, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h3C);
        vid(4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'h00);
        act(4'hF, 6'h3F);
        act(4'h1, 6'h02);
        act(4'h9, 6'h03);

        // Write then read back both banks; then a same-cycle write/read.
        wr(1'b1, 4'h3, 6'h2A);
        act(4'h0, 6'h00);
        rd(1'b1, 4'h3, 6'h2A);
        act(4'h0, 6'h00);
        rd(1'b0, 4'h3, 6'h0A);
        act(4'h0, 6'h00);
        wr(1'b0, 4'h9, 6'h15);
        rd(1'b0, 4'h9, 6'h15);
        act(4'h0, 6'h00);
        act(4'h9, 6'h15);

        // Forwarding: the write lands in the cycle idx 7 sits in stage 1.
        act(4'h7, 6'h2A);
        wr(1'b1, 4'h7, 6'h3F);
        act(4'h0, 6'h00);
        act(4'h7, 6'h2A);
        wr(1'b0, 4'h8, 6'h01);
        act(4'h0, 6'h00);
        vid(4'h7, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00);
        wr(1'b0, 4'h7, 6'h15);
        act(4'h0, 6'h00);
        act(4'h7, 6'h3F);
        wr(1'b0, 4'h7, 6'h3F);
        act(4'h0, 6'h00);
        act(4'h7, 6'h3F);
        act(4'h8, 6'h01);

        // Bank swap only on the vsync rising edge.
        bank_sel = 1'b1;
        act(4'h3, 6'h0A);
        check("swap_hold_a", {31'h0, act_bank}, 32'h0);
        act(4'h3, 6'h0A);
        check("swap_hold_b", {31'h0, act_bank}, 32'h0);
        vid(4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'h00);
        check("swap_edge_pending", {31'h0, act_bank}, 32'h0);
        vid(4'h3, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h2A);
        check("swap_done", {31'h0, act_bank}, 32'h1);
        bank_sel = 1'b0;
        vid(4'h7, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h3F);
        act(4'h9, 6'h03);
        check("swap_ignored", {31'h0, act_bank}, 32'h1);

        // Reset mid-line with a write in flight.
        wr(1'b1, 4'h3, 6'h3F);
        act(4'hE, 6'h3C);
        pixel = 4'hF; hpix = 1; vpix = 1;
        #3 rst_n = 1'b0;
        #1;
        check("midreset_outputs", {20'h0, vgrn, vred, vblu, vhsync, vvsync, vcsync}, 32'h0);
        check("midreset_act_bank", {31'h0, act_bank}, 32'h0);
        check("midreset_rd_data", {26'h0, rd_data}, 32'h0);
        vq.delete();
        rq.delete();
        chk_vid = 1'b0;
        wr(1'b0, 4'h3, 6'h3F);
        @(negedge clk);
        @(negedge clk);
        wr_stb = 1'b0;
        rst_n = 1'b1;
        rd(1'b0, 4'h3, 6'h0A);
        act(4'h7, 6'h2A);
        rd(1'b1, 4'h3, 6'h0A);
        act(4'h3, 6'h0A);
        rd(1'b0, 4'h7, 6'h2A);
        act(4'h0, 6'h00);
        rd(1'b1, 4'h7, 6'h2A);
        act(4'h0, 6'h00);

        for (int i = 0; i < 10 && (vq.size() != 0 || rq.size() != 0); i++) cyc();
        check("queues_drained", vq.size() + rq.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
